sigdel_cic_decim: RTL



---
 rtl/sigdel_cic_decim.sv | 107 ++++++++++
 1 files changed

// File: rtl/sigdel_cic_decim.sv
// rtl/sigdel_cic_decim.sv - Sinc^N (CIC) decimator for a 1-bit sigma-delta stream.
// Optional macro SIGDEL_BIPOLAR_OUT_EN selects two's-complement pcm_out.
module sigdel_cic_decim #(
  parameter int ORDER    = 3,
  parameter int OSR_LOG2 = 5,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sample_en,
  input  logic             bit_in,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid,
  output logic             settled
);

  localparam int W      = ORDER * OSR_LOG2 + 1;
  localparam int SHIFT  = W - 1 - OUT_W;
  localparam int EV_W   = 3;
  localparam logic [EV_W-1:0] EV_MAX = EV_W'(ORDER + 1);
  localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;
  localparam logic [OUT_W-1:0] PCM_MSB = OUT_W'(1) << (OUT_W - 1);

  logic [W-1:0]          integ     [ORDER];
  logic [W-1:0]          integ_nxt [ORDER];
  logic [W-1:0]          comb_d    [ORDER];
  logic [W-1:0]          comb_in   [ORDER];
  logic [W-1:0]          comb_acc;
  logic [W-1:0]          scaled;
  logic [OUT_W-1:0]      pcm_sat;
  logic [OUT_W-1:0]      pcm_fmt;
  logic [OSR_LOG2-1:0]   dec_cnt;
  logic [EV_W-1:0]       ev_cnt;
  logic                  dec_event;

  assign dec_event = sample_en && (dec_cnt == CNT_LAST);

  // All integrators advance together from their previous values.
  always_comb begin
    integ_nxt[0] = integ[0] + W'(bit_in);
    for (int k = 1; k < ORDER; k++) begin
      integ_nxt[k] = integ[k] + integ[k-1];
    end
  end

  // Comb chain fed by the next-state value of the last integrator.
  always_comb begin
    comb_acc = integ_nxt[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = comb_acc;
      comb_acc   = comb_acc - comb_d[k];
    end
  end

  always_comb begin
    scaled  = comb_acc >> SHIFT;
    pcm_sat = (|scaled[W-1:OUT_W]) ? '1 : scaled[OUT_W-1:0];
`ifdef SIGDEL_BIPOLAR_OUT_EN
    pcm_fmt = pcm_sat ^ PCM_MSB;
`else
    pcm_fmt = pcm_sat;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ORDER; k++) begin
        integ[k]  <= '0;
        comb_d[k] <= '0;
      end
      dec_cnt   <= '0;
      ev_cnt    <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      settled   <= 1'b0;
    end else if (clr) begin
      for (int k = 0; k < ORDER; k++) begin
        integ[k]  <= '0;
        comb_d[k] <= '0;
      end
      dec_cnt   <= '0;
      ev_cnt    <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      settled   <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      if (sample_en) begin
        integ   <= integ_nxt;
        dec_cnt <= dec_cnt + 1'b1;
      end
      // The first ORDER+1 events only flush the start-up transient.
      if (dec_event) begin
        comb_d <= comb_in;
        if (ev_cnt < EV_MAX) begin
          ev_cnt <= ev_cnt + 1'b1;
        end else begin
          pcm_out   <= pcm_fmt;
          pcm_valid <= 1'b1;
          settled   <= 1'b1;
        end
      end
    end
  end

endmodule
